// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and encodings for the pipeline sequencer.
// Optional operand forwarding is selected with the FWD_EN macro.
package pipeline_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RESET,
      ST_RUN,
      ST_FLUSH,
      ST_DRAIN,
      ST_HALT
   } state_e;

   localparam logic [4:0] OP_HLT  = 5'h1F;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Combinational RAW hazard detection between ID sources and EX/WB destinations.
// FWD_EN defined: forward from EX/WB and stall only on load-use; else stall on any match.
module hazard_unit
   import pipeline_ctrl_pkg::*;
(
   input  logic [2:0] id_rs1,
   input  logic [2:0] id_rs2,
   input  logic       id_use_rs1,
   input  logic       id_use_rs2,
   input  logic [2:0] ex_rd,
   input  logic       ex_wr_en,
   input  logic       ex_is_load,
   input  logic [2:0] wb_rd,
   input  logic       wb_wr_en,
   output logic       stall,
   output logic [1:0] fwd_sel_a,
   output logic [1:0] fwd_sel_b
);

   logic ex_match_a;
   logic ex_match_b;
   logic wb_match_a;
   logic wb_match_b;

   assign ex_match_a = id_use_rs1 && ex_wr_en && (ex_rd == id_rs1);
   assign ex_match_b = id_use_rs2 && ex_wr_en && (ex_rd == id_rs2);
   assign wb_match_a = id_use_rs1 && wb_wr_en && (wb_rd == id_rs1);
   assign wb_match_b = id_use_rs2 && wb_wr_en && (wb_rd == id_rs2);

`ifdef FWD_EN
   // The younger EX result wins over the older WB result.
   assign fwd_sel_a = ex_match_a ? FWD_EX : (wb_match_a ? FWD_WB : FWD_REG);
   assign fwd_sel_b = ex_match_b ? FWD_EX : (wb_match_b ? FWD_WB : FWD_REG);
   assign stall     = ex_is_load && (ex_match_a || ex_match_b);
`else
   logic unused_load;

   assign fwd_sel_a   = FWD_REG;
   assign fwd_sel_b   = FWD_REG;
   assign stall       = ex_match_a || ex_match_b || wb_match_a || wb_match_b;
   assign unused_load = ex_is_load;
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stage enables/flushes, branch redirect, HLT drain/resume, stall counter.
// Forwarding behaviour follows the FWD_EN macro (see hazard_unit).
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int STALL_CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [2:0]             id_rs1,
   input  logic [2:0]             id_rs2,
   input  logic                   id_use_rs1,
   input  logic                   id_use_rs2,
   input  logic [4:0]             ex_opcode,
   input  logic [2:0]             ex_rd,
   input  logic                   ex_wr_en,
   input  logic                   ex_is_load,
   input  logic [2:0]             wb_rd,
   input  logic                   wb_wr_en,
   input  logic                   branch_taken,
   input  logic [5:0]             branch_target,
   input  logic                   resume,
   output logic                   pc_en,
   output logic                   if_id_en,
   output logic                   id_ex_en,
   output logic                   ex_wb_en,
   output logic                   if_id_flush,
   output logic                   id_ex_flush,
   output logic                   pc_load,
   output logic [5:0]             pc_load_addr,
   output logic [1:0]             fwd_sel_a,
   output logic [1:0]             fwd_sel_b,
   output logic                   halted,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   state_e                 state_q, state_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic                   hz_stall;
   logic [1:0]             hz_fwd_a;
   logic [1:0]             hz_fwd_b;

   hazard_unit u_hazard (
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_use_rs1 (id_use_rs1),
      .id_use_rs2 (id_use_rs2),
      .ex_rd      (ex_rd),
      .ex_wr_en   (ex_wr_en),
      .ex_is_load (ex_is_load),
      .wb_rd      (wb_rd),
      .wb_wr_en   (wb_wr_en),
      .stall      (hz_stall),
      .fwd_sel_a  (hz_fwd_a),
      .fwd_sel_b  (hz_fwd_b)
   );

   always_comb begin
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      case (state_q)
         ST_RESET: state_d = ST_RUN;
         ST_RUN: begin
            if (branch_taken) begin
               state_d = ST_FLUSH;
            end else begin
               if (ex_opcode == OP_HLT) begin
                  state_d = ST_DRAIN;
               end
               if (hz_stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
                  stall_cnt_d = stall_cnt_q + 1'b1;
               end
            end
         end
         ST_FLUSH: state_d = ST_RUN;
         ST_DRAIN: state_d = ST_HALT;
         ST_HALT:  state_d = resume ? ST_FLUSH : ST_HALT;
         default:  state_d = ST_RESET;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_RESET;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Controls depend on the current inputs so they settle ahead of the same edge.
   always_comb begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_wb_en     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      pc_load      = 1'b0;
      pc_load_addr = '0;
      fwd_sel_a    = FWD_REG;
      fwd_sel_b    = FWD_REG;
      halted       = 1'b0;
      case (state_q)
         ST_RUN: begin
            fwd_sel_a = hz_fwd_a;
            fwd_sel_b = hz_fwd_b;
            if (branch_taken) begin
               pc_load      = 1'b1;
               pc_load_addr = branch_target;
               if_id_flush  = 1'b1;
               id_ex_flush  = 1'b1;
               ex_wb_en     = 1'b1;
            end else if (hz_stall) begin
               id_ex_flush  = 1'b1;
               ex_wb_en     = 1'b1;
            end else begin
               pc_en        = 1'b1;
               if_id_en     = 1'b1;
               id_ex_en     = 1'b1;
               ex_wb_en     = 1'b1;
            end
         end
         ST_FLUSH: begin
            pc_en       = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ex_wb_en    = 1'b1;
         end
         ST_DRAIN: begin
            id_ex_flush = 1'b1;
            ex_wb_en    = 1'b1;
         end
         ST_HALT: halted = 1'b1;
         default: begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end
      endcase
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a per-cycle expected-control scoreboard.
// Expectations for both FWD_EN builds are selected with the same macro.
module tb_pipeline_ctrl;

   typedef enum int {K_RESET, K_RUN, K_STALL, K_BRANCH, K_FLUSH, K_DRAIN, K_HALT} kind_e;

   typedef struct {
      logic [5:0] ctl;
      logic [5:0] care;
      logic       pl;
      logic [5:0] addr;
      logic [1:0] fa;
      logic [1:0] fb;
      logic       halted;
      int         cnt;
      string      name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] id_rs1 = '0, id_rs2 = '0;
   logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
   logic [4:0] ex_opcode = '0;
   logic [2:0] ex_rd = '0, wb_rd = '0;
   logic       ex_wr_en = 1'b0, ex_is_load = 1'b0, wb_wr_en = 1'b0;
   logic       branch_taken = 1'b0;
   logic [5:0] branch_target = '0;
   logic       resume = 1'b0;

   logic       pc_en, if_id_en, id_ex_en, ex_wb_en, if_id_flush, id_ex_flush;
   logic       pc_load, halted;
   logic [5:0] pc_load_addr;
   logic [1:0] fwd_sel_a, fwd_sel_b;
   logic [7:0] stall_cnt;

   int   errors = 0;
   int   checks = 0;
   int   exp_cnt = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   pipeline_ctrl #(.STALL_CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
      .wb_rd(wb_rd), .wb_wr_en(wb_wr_en),
      .branch_taken(branch_taken), .branch_target(branch_target), .resume(resume),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_wb_en(ex_wb_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .pc_load(pc_load), .pc_load_addr(pc_load_addr),
      .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
      .halted(halted), .stall_cnt(stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Bit order of ctl/care: pc_en, if_id_en, id_ex_en, ex_wb_en, if_id_flush, id_ex_flush
   function automatic exp_t mk(input kind_e k, input logic [5:0] addr,
                               input logic [1:0] fa, input logic [1:0] fb);
      exp_t e;
      e.pl = 1'b0; e.addr = 6'h00; e.fa = fa; e.fb = fb; e.halted = 1'b0;
      e.cnt = exp_cnt; e.name = k.name();
      case (k)
         K_RESET:  begin e.ctl = 6'b000011; e.care = 6'b111111; end
         K_RUN:    begin e.ctl = 6'b111100; e.care = 6'b111111; end
         K_STALL:  begin e.ctl = 6'b000101; e.care = 6'b110111; end
         K_BRANCH: begin e.ctl = 6'b000111; e.care = 6'b000111; e.pl = 1'b1; e.addr = addr; end
         K_FLUSH:  begin e.ctl = 6'b100111; e.care = 6'b100111; end
         K_DRAIN:  begin e.ctl = 6'b000101; e.care = 6'b110101; end
         default:  begin e.ctl = 6'b000000; e.care = 6'b111100; e.halted = 1'b1; end
      endcase
      return e;
   endfunction

   task automatic step(input kind_e k, input logic [5:0] addr,
                       input logic [1:0] fa, input logic [1:0] fb);
      exp_t e;
      logic [5:0] obs_ctl;
      sb.push_back(mk(k, addr, fa, fb));
      @(negedge clk);
      e = sb.pop_front();
      obs_ctl = {pc_en, if_id_en, id_ex_en, ex_wb_en, if_id_flush, id_ex_flush};
      chk({e.name, ".ctl"}, {26'd0, obs_ctl & e.care}, {26'd0, e.ctl & e.care});
      chk({e.name, ".pc_load"}, {31'd0, pc_load}, {31'd0, e.pl});
      chk({e.name, ".pc_load_addr"}, {26'd0, pc_load_addr}, {26'd0, e.addr});
      chk({e.name, ".fwd_sel"}, {28'd0, fwd_sel_a, fwd_sel_b}, {28'd0, e.fa, e.fb});
      chk({e.name, ".halted"}, {31'd0, halted}, {31'd0, e.halted});
      chk({e.name, ".stall_cnt"}, {24'd0, stall_cnt}, e.cnt);
      $display("t=%0t %s ctl=%b pc_load=%b addr=%h fwd=%b/%b halted=%b stall_cnt=%0d",
               $time, e.name, obs_ctl, pc_load, pc_load_addr, fwd_sel_a, fwd_sel_b,
               halted, stall_cnt);
      @(posedge clk);
      #1;
      if (k == K_STALL && exp_cnt < 255) exp_cnt++;
   endtask

   task automatic idle();
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_wr_en = 1'b0; ex_is_load = 1'b0;
      wb_wr_en = 1'b0; branch_taken = 1'b0; resume = 1'b0; ex_opcode = 5'h00;
   endtask

   initial begin
      // Reset and release
      step(K_RESET, 6'h00, 2'b00, 2'b00);
      rst = 1'b1;
      step(K_RESET, 6'h00, 2'b00, 2'b00);
      step(K_RUN, 6'h00, 2'b00, 2'b00);

      // EX RAW hazard on rs1, producer then moves to WB
      ex_rd = 3'd3; ex_wr_en = 1'b1; id_rs1 = 3'd3; id_use_rs1 = 1'b1;
`ifdef FWD_EN
      step(K_RUN, 6'h00, 2'b01, 2'b00);
      ex_wr_en = 1'b0; wb_rd = 3'd3; wb_wr_en = 1'b1;
      step(K_RUN, 6'h00, 2'b10, 2'b00);
`else
      step(K_STALL, 6'h00, 2'b00, 2'b00);
      ex_wr_en = 1'b0; wb_rd = 3'd3; wb_wr_en = 1'b1;
      step(K_STALL, 6'h00, 2'b00, 2'b00);
`endif
      idle();
      step(K_RUN, 6'h00, 2'b00, 2'b00);
      chk("ex_hazard.stall_cnt", {24'd0, stall_cnt}, exp_cnt);

      // Load-use on rs2
      ex_is_load = 1'b1; ex_rd = 3'd2; ex_wr_en = 1'b1; id_rs2 = 3'd2; id_use_rs2 = 1'b1;
`ifdef FWD_EN
      step(K_STALL, 6'h00, 2'b00, 2'b01);
      ex_is_load = 1'b0; ex_wr_en = 1'b0; wb_rd = 3'd2; wb_wr_en = 1'b1;
      step(K_RUN, 6'h00, 2'b00, 2'b10);
`else
      step(K_STALL, 6'h00, 2'b00, 2'b00);
      ex_is_load = 1'b0; ex_wr_en = 1'b0; wb_rd = 3'd2; wb_wr_en = 1'b1;
      step(K_STALL, 6'h00, 2'b00, 2'b00);
`endif
      idle();
      step(K_RUN, 6'h00, 2'b00, 2'b00);

      // Taken branch over an EX hazard; branch held high in FLUSH must be ignored
      ex_rd = 3'd3; ex_wr_en = 1'b1; id_rs1 = 3'd3; id_use_rs1 = 1'b1;
      branch_taken = 1'b1; branch_target = 6'h2A;
`ifdef FWD_EN
      step(K_BRANCH, 6'h2A, 2'b01, 2'b00);
`else
      step(K_BRANCH, 6'h2A, 2'b00, 2'b00);
`endif
      step(K_FLUSH, 6'h00, 2'b00, 2'b00);
      idle();
      step(K_RUN, 6'h00, 2'b00, 2'b00);

      // Resume outside HALT is ignored, then HLT drain, halt and resume
      resume = 1'b1;
      step(K_RUN, 6'h00, 2'b00, 2'b00);
      resume = 1'b0; ex_opcode = 5'h1F;
      step(K_RUN, 6'h00, 2'b00, 2'b00);
      ex_opcode = 5'h00;
      step(K_DRAIN, 6'h00, 2'b00, 2'b00);
      step(K_HALT, 6'h00, 2'b00, 2'b00);
      step(K_HALT, 6'h00, 2'b00, 2'b00);
      resume = 1'b1;
      step(K_HALT, 6'h00, 2'b00, 2'b00);
      resume = 1'b0;
      step(K_FLUSH, 6'h00, 2'b00, 2'b00);
      step(K_RUN, 6'h00, 2'b00, 2'b00);

      // Asynchronous reset in the middle of RUN
      rst = 1'b0;
      #2;
      exp_cnt = 0;
      chk("async_rst.pc_en", {31'd0, pc_en}, 32'd0);
      chk("async_rst.if_id_flush", {31'd0, if_id_flush}, 32'd1);
      chk("async_rst.stall_cnt", {24'd0, stall_cnt}, 32'd0);
      $display("t=%0t async reset pc_en=%b if_id_flush=%b stall_cnt=%0d",
               $time, pc_en, if_id_flush, stall_cnt);
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(K_RESET, 6'h00, 2'b00, 2'b00);
      step(K_RUN, 6'h00, 2'b00, 2'b00);

      // Saturation of the stall counter
      ex_rd = 3'd5; ex_wr_en = 1'b1; id_rs1 = 3'd5; id_use_rs1 = 1'b1;
`ifdef FWD_EN
      ex_is_load = 1'b1;
      for (int i = 0; i < 300; i++) step(K_STALL, 6'h00, 2'b01, 2'b00);
`else
      for (int i = 0; i < 300; i++) step(K_STALL, 6'h00, 2'b00, 2'b00);
`endif
      idle();
      step(K_RUN, 6'h00, 2'b00, 2'b00);
      chk("saturate.stall_cnt", {24'd0, stall_cnt}, 32'd255);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline sequencer for the 3-stage-latch core (IF → IF_ID → ID → ID_EX → EX → EX_WB → WB). It generates enable/flush controls for the PC and the IF_ID, ID_EX and EX_WB latches. It detects RAW hazards between the ID-stage sources and the EX/WB destinations, and sequences branch redirects, HLT drain and resume. It also keeps a saturating stall-cycle counter.

## Interface
Parameters:
- STALL_CNT_W, 8, width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  3 each  ID-stage source registers.
- id_use_rs1, id_use_rs2  in  1 each  source actually read.
- ex_opcode  in  5  opcode held in ID_EX (instruction in EX).
- ex_rd  in  3  EX destination.
- ex_wr_en  in  1  EX instruction writes the register file.
- ex_is_load  in  1  EX instruction is a data-memory load.
- wb_rd  in  3  destination held in EX_WB.
- wb_wr_en  in  1  WB instruction writes the register file.
- branch_taken  in  1  resolved taken branch/jump in EX.
- branch_target  in  6  instruction-memory target.
- resume  in  1  single-cycle pulse; leave HALT.
- pc_en, if_id_en, id_ex_en, ex_wb_en  out  1 each  stage advance enables.
- if_id_flush, id_ex_flush  out  1 each  load a bubble (NOP) into the latch.
- pc_load  out  1  load PC from pc_load_addr.
- pc_load_addr  out  6  redirect address.
- fwd_sel_a, fwd_sel_b  out  2 each  operand source: 00 regfile, 01 EX result, 10 WB result.
- halted  out  1  core in HALT.
- stall_cnt  out  STALL_CNT_W  hazard stall cycles since reset.

## Operation
- FSM states: RESET, RUN, FLUSH, DRAIN, HALT.
  - RESET → RUN on the first clock after rst deasserts.
  - RUN → FLUSH on branch_taken.
  - RUN → DRAIN when ex_opcode == OP_HLT and branch_taken == 0.
  - FLUSH → RUN.
  - DRAIN → HALT.
  - HALT → FLUSH on resume.
- RESET outputs:
  - All enables 0.
  - if_id_flush = 1, id_ex_flush = 1.
  - pc_load = 0, pc_load_addr = 0, fwd_sel = 00, halted = 0, stall_cnt = 0.
- Hazard match: a source matches when id_use_rsN is set, the destination's wr_en is set, and the register numbers are equal. EX match takes priority over WB match.
- RUN, no branch:
  - The stall condition is defined under Configuration.
  - On stall: pc_en = 0, if_id_en = 0, id_ex_flush = 1, ex_wb_en = 1, and stall_cnt increments.
  - Otherwise all enables are 1 and both flushes are 0.
- RUN with branch_taken:
  - pc_load = 1, pc_load_addr = branch_target.
  - if_id_flush = 1, id_ex_flush = 1, ex_wb_en = 1.
  - Any hazard stall is ignored and is not counted.
- FLUSH: one extra IF_ID bubble, because instruction memory reads synchronously.
  - pc_en = 1, if_id_flush = 1, id_ex_flush = 1, ex_wb_en = 1.
  - Hazard detection is disabled.
- DRAIN: pc_en = 0, if_id_en = 0, id_ex_flush = 1, ex_wb_en = 1, so the instruction ahead of HLT retires.
- HALT: all enables 0, halted = 1. A resume pulse takes the FSM to FLUSH, where the PC fetches the instruction after HLT.
- stall_cnt saturates at all-ones and never wraps.

## Timing
- Control outputs are combinational from the registered state and the current inputs; they are valid before the same rising edge.
- Only the state register and stall_cnt are registered.
- Branch penalty: 2 bubbles, i.e. the branch cycle plus FLUSH.
- HLT-in-EX to halted = 1: 2 clocks (DRAIN, then HALT).
- Reset mid-operation: outputs take their RESET values immediately (asynchronously), the state is forced to RESET, and stall_cnt clears.
- Coincident events:
  - A resume outside HALT is ignored.
  - branch_taken outside RUN is ignored (EX holds a bubble in FLUSH and DRAIN).

## Configuration
- FWD_EN defined:
  - fwd_sel = 01 on an EX match, 10 on a WB match.
  - Stall only for load-use: EX match with ex_is_load = 1, 1 cycle. The next cycle the load sits in WB and forwards via 10.
- FWD_EN undefined:
  - fwd_sel is tied to 00.
  - Any EX or WB match stalls. An EX match therefore stalls 2 cycles, a WB match 1 cycle (the register file is not write-through).

## Structure
- Package pipeline_ctrl_pkg holds:
  - the state enum (RESET, RUN, FLUSH, DRAIN, HALT);
  - OP_HLT = 5'h1F;
  - the FWD_REG/FWD_EX/FWD_WB encodings (00/01/10).
- Sub-module hazard_unit: purely combinational source/destination comparison. It produces the stall and fwd_sel outputs and is instantiated once.

## Test plan
- Reset: drop rst mid-RUN → pc_en = 0 and if_id_flush = 1 immediately, stall_cnt = 0. After release, 1 cycle in RESET, then RUN with pc_en = 1.
- EX RAW hazard: ex_rd = 3, ex_wr_en = 1, id_rs1 = 3, id_use_rs1 = 1.
  - With FWD_EN: fwd_sel_a = 01 and no stall.
  - Without: 2 stall cycles, stall_cnt = 2.
- Load-use: ex_is_load = 1, ex_rd = 2, id_rs2 = 2.
  - With FWD_EN: 1 stall cycle, then fwd_sel_b = 10.
  - stall_cnt = 1 (FWD_EN), 2 (no FWD_EN).
- Branch over hazard: branch_taken = 1, target 6'h2A, plus an EX hazard → pc_load = 1 with addr 2A and both flushes. Next cycle FLUSH with if_id_flush = 1, then RUN; stall_cnt unchanged.
- Halt/resume: ex_opcode = 5'h1F → DRAIN with ex_wb_en = 1, then HALT with halted = 1 and all enables 0. A resume pulse → FLUSH (pc_en = 1), then RUN.
- Saturation: hold a non-load EX hazard for 300 cycles without FWD_EN → stall_cnt = 255.
